// File: rtl/sdram_fifo_ctrl_param.sv
// rtl/sdram_fifo_ctrl_param.sv - burst FIFO front end between user logic and the SDRAM command core
// Define SDRAM_FIFO_STATUS_EN to add the sticky wr_fifo_ovf / rd_fifo_udf outputs.
module sdram_fifo_ctrl_param #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 23,
  parameter int LEN_W   = 10,
  parameter int FIFO_AW = 10
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               init_end,
  input  logic               wr_fifo_wr_req,
  input  logic [DATA_W-1:0]  wr_fifo_wr_data,
  input  logic [ADDR_W-1:0]  wr_b_addr,
  input  logic [ADDR_W-1:0]  wr_e_addr,
  input  logic [LEN_W-1:0]   wr_burst_len,
  output logic [FIFO_AW:0]   wr_fifo_num,
  input  logic               rd_fifo_rd_req,
  output logic [DATA_W-1:0]  rd_fifo_rd_data,
  input  logic [ADDR_W-1:0]  rd_b_addr,
  input  logic [ADDR_W-1:0]  rd_e_addr,
  input  logic [LEN_W-1:0]   rd_burst_len,
  input  logic               read_valid,
  output logic [FIFO_AW:0]   rd_fifo_num,
  output logic               sdram_wr_req,
  output logic               sdram_rd_req,
  input  logic               sdram_wr_ack,
  input  logic               sdram_rd_ack,
  output logic [ADDR_W-1:0]  sdram_wr_addr,
  output logic [ADDR_W-1:0]  sdram_rd_addr,
  output logic [DATA_W-1:0]  sdram_in_data,
`ifdef SDRAM_FIFO_STATUS_EN
  output logic               wr_fifo_ovf,
  output logic               rd_fifo_udf,
`endif
  input  logic [DATA_W-1:0]  sdram_out_data
);

  localparam int CW = FIFO_AW + 1;
  localparam int SW = ADDR_W + LEN_W + 1;
  localparam int PW = ((CW > LEN_W) ? CW : LEN_W) + 1;
  localparam int DEPTH_I = 1 << FIFO_AW;
  localparam logic [CW-1:0] DEPTH = CW'(DEPTH_I);

  typedef enum logic [2:0] {S_IDLE, S_WR_REQ, S_WR_RUN, S_RD_REQ, S_RD_RUN} state_t;

  // Write FIFO: show-ahead head drives sdram_in_data, popped by the core's ack.
  logic [DATA_W-1:0]  r_wf_mem [DEPTH_I];
  logic [FIFO_AW-1:0] r_wf_wp, r_wf_rp;
  logic [CW-1:0]      r_wf_cnt;
  logic               w_wf_push, w_wf_pop, w_wf_full, w_wf_empty;

  assign w_wf_full  = (r_wf_cnt == DEPTH);
  assign w_wf_empty = (r_wf_cnt == '0);
  assign w_wf_push  = wr_fifo_wr_req && !w_wf_full;
  assign w_wf_pop   = sdram_wr_ack && !w_wf_empty;

  always_ff @(posedge sys_clk) begin
    if (w_wf_push) r_wf_mem[r_wf_wp] <= wr_fifo_wr_data;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wf_wp  <= '0;
      r_wf_rp  <= '0;
      r_wf_cnt <= '0;
    end else begin
      if (w_wf_push) r_wf_wp <= r_wf_wp + FIFO_AW'(1);
      if (w_wf_pop)  r_wf_rp <= r_wf_rp + FIFO_AW'(1);
      if (w_wf_push && !w_wf_pop)      r_wf_cnt <= r_wf_cnt + CW'(1);
      else if (!w_wf_push && w_wf_pop) r_wf_cnt <= r_wf_cnt - CW'(1);
    end
  end

  assign sdram_in_data = r_wf_mem[r_wf_rp];
  assign wr_fifo_num   = r_wf_cnt;

  // Read FIFO: filled by the core's ack, registered output towards the user.
  logic [DATA_W-1:0]  r_rf_mem [DEPTH_I];
  logic [FIFO_AW-1:0] r_rf_wp, r_rf_rp;
  logic [CW-1:0]      r_rf_cnt;
  logic [DATA_W-1:0]  r_rd_data;
  logic               w_rf_push, w_rf_pop, w_rf_full, w_rf_empty;

  assign w_rf_full  = (r_rf_cnt == DEPTH);
  assign w_rf_empty = (r_rf_cnt == '0);
  assign w_rf_push  = sdram_rd_ack && !w_rf_full;
  assign w_rf_pop   = rd_fifo_rd_req && !w_rf_empty;

  always_ff @(posedge sys_clk) begin
    if (w_rf_push) r_rf_mem[r_rf_wp] <= sdram_out_data;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rf_wp   <= '0;
      r_rf_rp   <= '0;
      r_rf_cnt  <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_rf_push) r_rf_wp <= r_rf_wp + FIFO_AW'(1);
      if (w_rf_pop) begin
        r_rf_rp   <= r_rf_rp + FIFO_AW'(1);
        r_rd_data <= r_rf_mem[r_rf_rp];
      end
      if (w_rf_push && !w_rf_pop)      r_rf_cnt <= r_rf_cnt + CW'(1);
      else if (!w_rf_push && w_rf_pop) r_rf_cnt <= r_rf_cnt - CW'(1);
    end
  end

  assign rd_fifo_rd_data = r_rd_data;
  assign rd_fifo_num     = r_rf_cnt;

  // Pending conditions; the read side only prefetches a burst that is certain to fit.
  logic w_wr_pend, w_rd_pend;
  assign w_wr_pend = (PW'(r_wf_cnt) >= PW'(wr_burst_len)) && (wr_burst_len != '0);
  assign w_rd_pend = read_valid && (rd_burst_len != '0) &&
                     ((PW'(r_rf_cnt) + PW'(rd_burst_len)) <= PW'(DEPTH));

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [ADDR_W-1:0] b,
                                                  input logic [ADDR_W-1:0] e,
                                                  input logic [LEN_W-1:0]  len);
    logic [SW-1:0] w_end;
    w_end = SW'(a) + (SW'(len) << 1);
    return (w_end <= SW'(e)) ? ADDR_W'(SW'(a) + SW'(len)) : b;
  endfunction

  state_t r_state, w_next;
  logic   r_last_wr, r_wr_ack_d1, r_rd_ack_d1;
  logic   r_wr_addr_q, r_unused;
  logic [ADDR_W-1:0] r_wr_addr, r_rd_addr;
  logic   w_wr_done, w_rd_done;

  assign w_wr_done = (r_state == S_WR_RUN) && r_wr_ack_d1 && !sdram_wr_ack;
  assign w_rd_done = (r_state == S_RD_RUN) && r_rd_ack_d1 && !sdram_rd_ack;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (init_end) begin
          if (w_wr_pend && w_rd_pend) w_next = r_last_wr ? S_RD_REQ : S_WR_REQ;
          else if (w_wr_pend)         w_next = S_WR_REQ;
          else if (w_rd_pend)         w_next = S_RD_REQ;
        end
      end
      S_WR_REQ: if (sdram_wr_ack) w_next = S_WR_RUN;
      S_WR_RUN: if (w_wr_done)    w_next = S_IDLE;
      S_RD_REQ: if (sdram_rd_ack) w_next = S_RD_RUN;
      S_RD_RUN: if (w_rd_done)    w_next = S_IDLE;
      default:                    w_next = S_IDLE;
    endcase
  end

  // Burst addresses follow the region inputs while reset is held.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= S_IDLE;
      r_last_wr   <= 1'b0;
      r_wr_ack_d1 <= 1'b0;
      r_rd_ack_d1 <= 1'b0;
      r_wr_addr   <= wr_b_addr;
      r_rd_addr   <= rd_b_addr;
    end else begin
      r_state     <= w_next;
      r_wr_ack_d1 <= sdram_wr_ack;
      r_rd_ack_d1 <= sdram_rd_ack;
      if (w_wr_done) begin
        r_wr_addr <= next_addr(r_wr_addr, wr_b_addr, wr_e_addr, wr_burst_len);
        r_last_wr <= 1'b1;
      end
      if (w_rd_done) begin
        r_rd_addr <= next_addr(r_rd_addr, rd_b_addr, rd_e_addr, rd_burst_len);
        r_last_wr <= 1'b0;
      end
    end
  end

  assign sdram_wr_req  = (r_state == S_WR_REQ);
  assign sdram_rd_req  = (r_state == S_RD_REQ);
  assign sdram_wr_addr = r_wr_addr;
  assign sdram_rd_addr = r_rd_addr;

`ifdef SDRAM_FIFO_STATUS_EN
  logic r_wr_ovf, r_rd_udf;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wr_ovf <= 1'b0;
      r_rd_udf <= 1'b0;
    end else begin
      if (wr_fifo_wr_req && w_wf_full)  r_wr_ovf <= 1'b1;
      if (rd_fifo_rd_req && w_rf_empty) r_rd_udf <= 1'b1;
    end
  end
  assign wr_fifo_ovf = r_wr_ovf;
  assign rd_fifo_udf = r_rd_udf;
`else
  // Dropped pushes and ignored pops are absorbed silently in this build.
`endif

endmodule
